// File: rtl/dmem_arbiter.sv
// Single-port data memory controller shared by a core port (A) and a loader/debug port (B).
// Round-robin arbitration on conflict; sub-word stores are sequenced as read-modify-write.
module dmem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            a_req_valid,
    output logic            a_req_ready,
    input  logic            a_req_we,
    input  logic [DW/8-1:0] a_req_be,
    input  logic [AW-1:0]   a_req_addr,
    input  logic [DW-1:0]   a_req_wdata,
    output logic            a_rsp_valid,
    output logic [DW-1:0]   a_rsp_rdata,

    input  logic            b_req_valid,
    output logic            b_req_ready,
    input  logic            b_req_we,
    input  logic [DW/8-1:0] b_req_be,
    input  logic [AW-1:0]   b_req_addr,
    input  logic [DW-1:0]   b_req_wdata,
    output logic            b_rsp_valid,
    output logic [DW-1:0]   b_rsp_rdata,

    output logic            mem_memw,
    output logic [AW-1:0]   mem_address,
    output logic [DW-1:0]   mem_data_write,
    input  logic [DW-1:0]   mem_data_read
);

    localparam int BW = DW / 8;

    typedef enum logic {IDLE, MERGE} state_t;

    state_t          state_q, state_d;
    logic            lastGrantB_q, lastGrantB_d;
    logic [AW-1:0]   memAddr_q, memAddr_d;
    logic [DW-1:0]   memWdata_q, memWdata_d;
    logic            aRspValid_q, aRspValid_d;
    logic            bRspValid_q, bRspValid_d;
    logic [DW-1:0]   aRdata_q, aRdata_d;
    logic [DW-1:0]   bRdata_q, bRdata_d;
    logic [AW-1:0]   mergeAddr_q, mergeAddr_d;
    logic [DW-1:0]   mergeWdata_q, mergeWdata_d;
    logic [DW-1:0]   mergeRdata_q, mergeRdata_d;
    logic [BW-1:0]   mergeBe_q, mergeBe_d;
    logic            mergePortB_q, mergePortB_d;

    logic            grantA, grantB, grant;
    logic            selWe;
    logic [BW-1:0]   selBe;
    logic [AW-1:0]   selAddr;
    logic [DW-1:0]   selWdata;
    logic            isFullStore, isPartialStore;
    logic            inMerge;
    logic [DW-1:0]   mergeWord;

    // Grants are gated by rst_n so nothing reaches the memory while reset is held.
    always_comb begin
        grantA   = rst_n && (state_q == IDLE) && a_req_valid && (!b_req_valid || lastGrantB_q);
        grantB   = rst_n && (state_q == IDLE) && b_req_valid && (!a_req_valid || !lastGrantB_q);
        grant    = grantA || grantB;
        inMerge  = rst_n && (state_q == MERGE);
        selWe    = grantB ? b_req_we    : a_req_we;
        selBe    = grantB ? b_req_be    : a_req_be;
        selAddr  = grantB ? b_req_addr  : a_req_addr;
        selWdata = grantB ? b_req_wdata : a_req_wdata;
        isFullStore    = selWe && (selBe == {BW{1'b1}});
        isPartialStore = selWe && (selBe != '0) && !isFullStore;
    end

    always_comb begin
        mergeWord = mergeRdata_q;
        for (int i = 0; i < BW; i++) begin
            if (mergeBe_q[i]) begin
                mergeWord[8*i +: 8] = mergeWdata_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        lastGrantB_d = lastGrantB_q;
        memAddr_d    = memAddr_q;
        memWdata_d   = memWdata_q;
        aRdata_d     = aRdata_q;
        bRdata_d     = bRdata_q;
        mergeAddr_d  = mergeAddr_q;
        mergeWdata_d = mergeWdata_q;
        mergeRdata_d = mergeRdata_q;
        mergeBe_d    = mergeBe_q;
        mergePortB_d = mergePortB_q;
        aRspValid_d  = 1'b0;
        bRspValid_d  = 1'b0;
        mem_memw     = 1'b0;

        if (grant) begin
            lastGrantB_d = grantB;
            memAddr_d    = selAddr;
            if (isFullStore) begin
                mem_memw   = 1'b1;
                memWdata_d = selWdata;
            end
            if (isPartialStore) begin
                state_d      = MERGE;
                mergeAddr_d  = selAddr;
                mergeWdata_d = selWdata;
                mergeRdata_d = mem_data_read;
                mergeBe_d    = selBe;
                mergePortB_d = grantB;
            end else begin
                aRspValid_d = grantA;
                bRspValid_d = grantB;
            end
            if (!selWe && grantA) aRdata_d = mem_data_read;
            if (!selWe && grantB) bRdata_d = mem_data_read;
        end else if (inMerge) begin
            state_d     = IDLE;
            mem_memw    = 1'b1;
            memAddr_d   = mergeAddr_q;
            memWdata_d  = mergeWord;
            aRspValid_d = !mergePortB_q;
            bRspValid_d = mergePortB_q;
        end

        mem_address    = memAddr_d;
        mem_data_write = memWdata_d;
        a_req_ready    = grantA;
        b_req_ready    = grantB;
        a_rsp_valid    = aRspValid_q;
        b_rsp_valid    = bRspValid_q;
        a_rsp_rdata    = aRdata_q;
        b_rsp_rdata    = bRdata_q;
    end

    // Reset points last grant at B so that A wins the first conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lastGrantB_q <= 1'b1;
            memAddr_q    <= '0;
            memWdata_q   <= '0;
            aRspValid_q  <= 1'b0;
            bRspValid_q  <= 1'b0;
            aRdata_q     <= '0;
            bRdata_q     <= '0;
            mergeAddr_q  <= '0;
            mergeWdata_q <= '0;
            mergeRdata_q <= '0;
            mergeBe_q    <= '0;
            mergePortB_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lastGrantB_q <= lastGrantB_d;
            memAddr_q    <= memAddr_d;
            memWdata_q   <= memWdata_d;
            aRspValid_q  <= aRspValid_d;
            bRspValid_q  <= bRspValid_d;
            aRdata_q     <= aRdata_d;
            bRdata_q     <= bRdata_d;
            mergeAddr_q  <= mergeAddr_d;
            mergeWdata_q <= mergeWdata_d;
            mergeRdata_q <= mergeRdata_d;
            mergeBe_q    <= mergeBe_d;
            mergePortB_q <= mergePortB_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Table-driven bench for dmem_arbiter with a small behavioural word memory on the memory side.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid;
    logic [3:0]  a_req_be;
    logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
    logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid;
    logic [3:0]  b_req_be;
    logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
    logic        mem_memw;
    logic [31:0] mem_address, mem_data_write, mem_data_read;

    logic [31:0] memArr [0:63];

    int vectorCount = 0;
    int missCount   = 0;

    dmem_arbiter #(.AW(32), .DW(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .a_req_valid    (a_req_valid),
        .a_req_ready    (a_req_ready),
        .a_req_we       (a_req_we),
        .a_req_be       (a_req_be),
        .a_req_addr     (a_req_addr),
        .a_req_wdata    (a_req_wdata),
        .a_rsp_valid    (a_rsp_valid),
        .a_rsp_rdata    (a_rsp_rdata),
        .b_req_valid    (b_req_valid),
        .b_req_ready    (b_req_ready),
        .b_req_we       (b_req_we),
        .b_req_be       (b_req_be),
        .b_req_addr     (b_req_addr),
        .b_req_wdata    (b_req_wdata),
        .b_rsp_valid    (b_rsp_valid),
        .b_rsp_rdata    (b_rsp_rdata),
        .mem_memw       (mem_memw),
        .mem_address    (mem_address),
        .mem_data_write (mem_data_write),
        .mem_data_read  (mem_data_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory: combinational read, write on posedge when enabled.
    assign mem_data_read = memArr[mem_address[7:2]];
    always @(posedge clk) begin
        if (mem_memw) memArr[mem_address[7:2]] <= mem_data_write;
    end

    typedef struct {
        logic        aV;
        logic        aWe;
        logic [3:0]  aBe;
        logic [31:0] aAddr;
        logic [31:0] aWd;
        logic        bV;
        logic        bWe;
        logic [3:0]  bBe;
        logic [31:0] bAddr;
        logic [31:0] bWd;
        logic        eARdy;
        logic        eBRdy;
        logic        eMemw;
        logic [31:0] eAddr;
        logic [31:0] eWdata;
        logic        eARspV;
        logic        eBRspV;
        logic [31:0] eARdata;
        logic [31:0] eBRdata;
    } vec_t;

    vec_t vecs [0:14];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        a_req_valid = v.aV;  a_req_we = v.aWe;  a_req_be = v.aBe;
        a_req_addr  = v.aAddr; a_req_wdata = v.aWd;
        b_req_valid = v.bV;  b_req_we = v.bWe;  b_req_be = v.bBe;
        b_req_addr  = v.bAddr; b_req_wdata = v.bWd;
    endtask

    task automatic idleInputs();
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_be = 4'h0; a_req_addr = 32'h0; a_req_wdata = 32'h0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_be = 4'h0; b_req_addr = 32'h0; b_req_wdata = 32'h0;
    endtask

    initial begin
        //            aV    aWe   aBe   aAddr  aWd           bV    bWe   bBe   bAddr  bWd           aRdy  bRdy  memw  addr   wdata         aRspV bRspV aRdata        bRdata
        vecs[0]  = '{1'b0,1'b0,4'h0,32'h00,32'h0,        1'b0,1'b0,4'h0,32'h00,32'h0,        1'b0,1'b0,1'b0,32'h00,32'h0,        1'b0,1'b0,32'h0,        32'h0};
        vecs[1]  = '{1'b1,1'b1,4'hF,32'h10,32'hDEADBEEF, 1'b1,1'b0,4'h0,32'h20,32'h0,        1'b1,1'b0,1'b1,32'h10,32'hDEADBEEF, 1'b0,1'b0,32'h0,        32'h0};
        vecs[2]  = '{1'b1,1'b0,4'h0,32'h10,32'h0,        1'b1,1'b0,4'h0,32'h20,32'h0,        1'b0,1'b1,1'b0,32'h20,32'hDEADBEEF, 1'b1,1'b0,32'h0,        32'h0};
        vecs[3]  = '{1'b1,1'b0,4'h0,32'h10,32'h0,        1'b0,1'b0,4'h0,32'h00,32'h0,        1'b1,1'b0,1'b0,32'h10,32'hDEADBEEF, 1'b0,1'b1,32'h0,        32'h11223344};
        vecs[4]  = '{1'b0,1'b0,4'h0,32'h00,32'h0,        1'b0,1'b0,4'h0,32'h00,32'h0,        1'b0,1'b0,1'b0,32'h10,32'hDEADBEEF, 1'b1,1'b0,32'hDEADBEEF, 32'h11223344};
        vecs[5]  = '{1'b1,1'b0,4'h0,32'h30,32'h0,        1'b1,1'b1,4'h2,32'h20,32'h0000AA00, 1'b0,1'b1,1'b0,32'h20,32'hDEADBEEF, 1'b0,1'b0,32'hDEADBEEF, 32'h11223344};
        vecs[6]  = '{1'b1,1'b0,4'h0,32'h30,32'h0,        1'b0,1'b0,4'h0,32'h00,32'h0,        1'b0,1'b0,1'b1,32'h20,32'h1122AA44, 1'b0,1'b0,32'hDEADBEEF, 32'h11223344};
        vecs[7]  = '{1'b1,1'b0,4'h0,32'h30,32'h0,        1'b0,1'b0,4'h0,32'h00,32'h0,        1'b1,1'b0,1'b0,32'h30,32'h1122AA44, 1'b0,1'b1,32'hDEADBEEF, 32'h11223344};
        vecs[8]  = '{1'b1,1'b0,4'h0,32'h20,32'h0,        1'b1,1'b0,4'h0,32'h20,32'h0,        1'b0,1'b1,1'b0,32'h20,32'h1122AA44, 1'b1,1'b0,32'h00000055, 32'h11223344};
        vecs[9]  = '{1'b1,1'b0,4'h0,32'h20,32'h0,        1'b1,1'b0,4'h0,32'h10,32'h0,        1'b1,1'b0,1'b0,32'h20,32'h1122AA44, 1'b0,1'b1,32'h00000055, 32'h1122AA44};
        vecs[10] = '{1'b1,1'b1,4'h0,32'h30,32'hFFFFFFFF, 1'b1,1'b0,4'h0,32'h10,32'h0,        1'b0,1'b1,1'b0,32'h10,32'h1122AA44, 1'b1,1'b0,32'h1122AA44, 32'h1122AA44};
        vecs[11] = '{1'b1,1'b1,4'h0,32'h30,32'hFFFFFFFF, 1'b0,1'b0,4'h0,32'h00,32'h0,        1'b1,1'b0,1'b0,32'h30,32'h1122AA44, 1'b0,1'b1,32'h1122AA44, 32'hDEADBEEF};
        vecs[12] = '{1'b1,1'b0,4'h0,32'h30,32'h0,        1'b0,1'b0,4'h0,32'h00,32'h0,        1'b1,1'b0,1'b0,32'h30,32'h1122AA44, 1'b1,1'b0,32'h1122AA44, 32'hDEADBEEF};
        vecs[13] = '{1'b0,1'b0,4'h0,32'h00,32'h0,        1'b0,1'b0,4'h0,32'h00,32'h0,        1'b0,1'b0,1'b0,32'h30,32'h1122AA44, 1'b1,1'b0,32'h00000055, 32'hDEADBEEF};
        vecs[14] = '{1'b0,1'b0,4'h0,32'h00,32'h0,        1'b0,1'b0,4'h0,32'h00,32'h0,        1'b0,1'b0,1'b0,32'h30,32'h1122AA44, 1'b0,1'b0,32'h00000055, 32'hDEADBEEF};

        for (int i = 0; i < 64; i++) memArr[i] = 32'h0;
        memArr[32'h20 >> 2] = 32'h11223344;
        memArr[32'h30 >> 2] = 32'h00000055;
        memArr[32'h40 >> 2] = 32'hCAFEF00D;

        // A full store offered while reset is held must not reach the memory.
        idleInputs();
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_be = 4'hF; a_req_addr = 32'h14; a_req_wdata = 32'h12345678;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        vectorCount++;
        checkOutput("reset a_req_ready", {31'h0, a_req_ready}, 32'h0);
        checkOutput("reset mem_memw", {31'h0, mem_memw}, 32'h0);
        checkOutput("reset mem_address", mem_address, 32'h0);
        checkOutput("reset a_rsp_valid", {31'h0, a_rsp_valid}, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("reset no write", memArr[32'h14 >> 2], 32'h0);
        @(negedge clk);
        idleInputs();
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #2;
            vectorCount++;
            checkOutput($sformatf("v%0d a_req_ready", i), {31'h0, a_req_ready}, {31'h0, vecs[i].eARdy});
            checkOutput($sformatf("v%0d b_req_ready", i), {31'h0, b_req_ready}, {31'h0, vecs[i].eBRdy});
            checkOutput($sformatf("v%0d mem_memw", i), {31'h0, mem_memw}, {31'h0, vecs[i].eMemw});
            checkOutput($sformatf("v%0d mem_address", i), mem_address, vecs[i].eAddr);
            checkOutput($sformatf("v%0d mem_data_write", i), mem_data_write, vecs[i].eWdata);
            checkOutput($sformatf("v%0d a_rsp_valid", i), {31'h0, a_rsp_valid}, {31'h0, vecs[i].eARspV});
            checkOutput($sformatf("v%0d b_rsp_valid", i), {31'h0, b_rsp_valid}, {31'h0, vecs[i].eBRspV});
            checkOutput($sformatf("v%0d a_rsp_rdata", i), a_rsp_rdata, vecs[i].eARdata);
            checkOutput($sformatf("v%0d b_rsp_rdata", i), b_rsp_rdata, vecs[i].eBRdata);
        end

        // Partial store from A, then reset lands in the middle of its MERGE cycle.
        @(negedge clk);
        idleInputs();
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_be = 4'h1; a_req_addr = 32'h40; a_req_wdata = 32'h000000EE;
        #2;
        vectorCount++;
        checkOutput("rmw grant a_req_ready", {31'h0, a_req_ready}, 32'h1);
        checkOutput("rmw grant mem_memw", {31'h0, mem_memw}, 32'h0);
        @(negedge clk);
        idleInputs();
        #2;
        vectorCount++;
        checkOutput("merge mem_memw", {31'h0, mem_memw}, 32'h1);
        checkOutput("merge mem_data_write", mem_data_write, 32'hCAFEF0EE);
        #1;
        rst_n = 1'b0;
        #1;
        vectorCount++;
        checkOutput("reset in merge mem_memw", {31'h0, mem_memw}, 32'h0);
        checkOutput("reset in merge mem_address", mem_address, 32'h0);
        checkOutput("reset in merge mem_data_write", mem_data_write, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("reset in merge a_rsp_valid", {31'h0, a_rsp_valid}, 32'h0);
        checkOutput("reset in merge word kept", memArr[32'h40 >> 2], 32'hCAFEF00D);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        checkOutput("after reset a_rsp_valid", {31'h0, a_rsp_valid}, 32'h0);

        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'h40;
        b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 32'h10;
        #2;
        vectorCount++;
        checkOutput("post-reset conflict a_req_ready", {31'h0, a_req_ready}, 32'h1);
        checkOutput("post-reset conflict b_req_ready", {31'h0, b_req_ready}, 32'h0);
        @(negedge clk);
        idleInputs();
        #2;
        vectorCount++;
        checkOutput("post-reset a_rsp_valid", {31'h0, a_rsp_valid}, 32'h1);
        checkOutput("post-reset a_rsp_rdata", a_rsp_rdata, 32'hCAFEF00D);
        checkOutput("post-reset b_rsp_valid", {31'h0, b_rsp_valid}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
